// File: rtl/gf180_ram_pkg.sv
// Shared constants, state encoding and sizing helpers for the GF180 RAM array controller.
package gf180_ram_pkg;

  localparam int MACRO_AW    = 9;
  localparam int MACRO_DW    = 8;
  localparam int MACRO_DEPTH = 512;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Width of a register that holds a bank index; never narrower than one bit.
  function automatic int bank_idx_w(input int banks);
    return (banks <= 1) ? 1 : $clog2(banks);
  endfunction

  // Number of word-address bits above the macro row that select a bank.
  function automatic int bank_addr_bits(input int banks);
    return (banks <= 1) ? 0 : $clog2(banks);
  endfunction

endpackage

// File: rtl/gf180_ram_512x8x1.sv
// Behavioural wrapper of the 512x8 single-port GF180 SRAM macro.
// All controls are active-low; Q is registered and holds between reads.
module gf180_ram_512x8x1
  import gf180_ram_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire                 VDD,
  inout  wire                 VSS,
`endif
  input  logic                CLK,
  input  logic                CEN,
  input  logic                GWEN,
  input  logic [MACRO_DW-1:0] WEN,
  input  logic [MACRO_AW-1:0] A,
  input  logic [MACRO_DW-1:0] D,
  output logic [MACRO_DW-1:0] Q
);

  logic [MACRO_DW-1:0] mem [MACRO_DEPTH];

  // Enabled cycle either writes the bits whose WEN is low or reads the row into Q.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/gf180_ram_array_ctrl.sv
// BANKS x BYTES grid of 512x8 macros behind a picorv32-style valid/ready word port.
// Adds byte strobes, bank decoding, out-of-range protection and optional zero-fill.
module gf180_ram_array_ctrl
  import gf180_ram_pkg::*;
#(
  parameter int BYTES          = 4,
  parameter int BANKS          = 2,
  parameter int CLEAR_ON_RESET = 1,
  localparam int DATA_W        = 8 * BYTES,
  localparam int ADDR_W        = MACRO_AW + bank_addr_bits(BANKS)
) (
`ifdef USE_POWER_PINS
  inout  wire               VDD,
  inout  wire               VSS,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [BYTES-1:0]  mem_wstrb,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
);

  localparam int BW = bank_idx_w(BANKS);
  localparam logic [BW:0] BANKS_W = (BW + 1)'(BANKS);

  state_t                         state;
  logic [MACRO_AW-1:0]            clr_cnt;
  logic [BW-1:0]                  bank_q;
  logic                           rd_q;

  logic [BW-1:0]                  bank_sel;
  logic [MACRO_AW-1:0]            row;
  logic                           in_range;

  logic [BANKS-1:0]               cen_n;
  logic                           gwen_n;
  logic [DATA_W-1:0]              wen_n;
  logic [MACRO_AW-1:0]            a;
  logic [DATA_W-1:0]              d;
  logic [BANKS-1:0][DATA_W-1:0]   q;

  assign row = mem_addr[MACRO_AW-1:0];

  if (BANKS > 1) begin : g_bank_dec
    assign bank_sel = mem_addr[ADDR_W-1:MACRO_AW];
  end else begin : g_single_bank
    assign bank_sel = '0;
  end

  // Indices past the last populated bank exist only for non-power-of-2 BANKS.
  assign in_range = ({1'b0, bank_sel} < BANKS_W);

  // Macro controls: full-array zero write while clearing, one bank during an IDLE issue.
  always_comb begin
    cen_n  = '1;
    gwen_n = 1'b1;
    wen_n  = '1;
    a      = row;
    d      = mem_wdata;
    case (state)
      CLEAR: begin
        cen_n  = '0;
        gwen_n = 1'b0;
        wen_n  = '0;
        a      = clr_cnt;
        d      = '0;
      end
      IDLE: begin
        if (mem_valid && in_range) begin
          for (int k = 0; k < BANKS; k++) begin
            if (bank_sel == BW'(k)) cen_n[k] = 1'b0;
          end
          gwen_n = ~|mem_wstrb;
          for (int b = 0; b < BYTES; b++) begin
            wen_n[b*8 +: 8] = {8{~mem_wstrb[b]}};
          end
        end
      end
      default: ;
    endcase
  end

  // Controller FSM: zero-fill, accept one request, pulse ready for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt   <= '0;
      init_done <= (CLEAR_ON_RESET == 0);
      mem_ready <= 1'b0;
      bank_q    <= '0;
      rd_q      <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == MACRO_AW'(MACRO_DEPTH - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (mem_valid) begin
            bank_q    <= bank_sel;
            rd_q      <= (~|mem_wstrb) & in_range;
            mem_ready <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Read data is the registered bank's macro output, forced to zero outside a read response.
  always_comb begin
    mem_rdata = '0;
    if (mem_ready && rd_q) begin
      for (int k = 0; k < BANKS; k++) begin
        if (bank_q == BW'(k)) mem_rdata = q[k];
      end
    end
  end

  for (genvar gb = 0; gb < BANKS; gb++) begin : g_bank
    for (genvar gl = 0; gl < BYTES; gl++) begin : g_lane
      gf180_ram_512x8x1 u_ram (
`ifdef USE_POWER_PINS
        .VDD  (VDD),
        .VSS  (VSS),
`endif
        .CLK  (clk),
        .CEN  (cen_n[gb]),
        .GWEN (gwen_n),
        .WEN  (wen_n[gl*8 +: 8]),
        .A    (a),
        .D    (d[gl*8 +: 8]),
        .Q    (q[gb][gl*8 +: 8])
      );
    end
  end

endmodule
